// File: rtl/countdown_pkg.sv
// countdown_pkg: shared definitions for the countdown timer.
//   state_e       - controller state encoding (IDLE, RUN, EXPIRED)
//   WIDTH_DEFAULT - default counter/data width in bits
package countdown_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot / auto-reload modes.
// Ports:
//   clock   - rising-edge system clock
//   reset   - synchronous active-high reset
//   enable  - count qualifier (decrement or reload this cycle)
//   load    - parallel load strobe, wins over enable
//   data    - load value, also captured as the reload value
//   mode    - 0 one-shot, 1 auto-reload; captured only on load
//   count   - current registered count
//   tc      - registered one-cycle pulse when count reaches 0 by decrement
//   busy    - state == RUN
//   expired - state == EXPIRED
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             expired
);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q,   mode_d;
  logic             tc_q,     tc_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;

    if (load) begin
      // Load beats a pending terminal count: tc stays low.
      count_d  = data;
      reload_d = data;
      mode_d   = mode;
      state_d  = (data != '0) ? RUN : EXPIRED;
    end else if (enable && state_q == RUN) begin
      if (count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (count_q == WIDTH'(1)) begin
        count_d = '0;
        tc_d    = 1'b1;
      end else if (mode_q) begin
        // Sitting at 0 in auto-reload: the reload cycle makes the
        // period reload+1 enabled cycles.
        count_d = reload_q;
      end else begin
        // One-shot parked at 0: retire without touching count.
        state_d = EXPIRED;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign busy    = (state_q == RUN);
  assign expired = (state_q == EXPIRED);

endmodule
